// File: rtl/uart_rx_deframe_pkg.sv
// Shared UART definitions: parity encodings, receiver FSM states and the
// parity helper used by both the transmit and receive paths.
package uart_rx_deframe_pkg;

    localparam logic [1:0] PARITY_NONE     = 2'b00;
    localparam logic [1:0] PARITY_ODD      = 2'b01;
    localparam logic [1:0] PARITY_EVEN     = 2'b10;
    localparam logic [1:0] PARITY_NONE_ALT = 2'b11;

    localparam int unsigned PARITY_MAX_WIDTH = 32;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP,
        ST_BREAK
    } rx_state_e;

    // Expected parity bit; data is zero-extended, which leaves the XOR unchanged.
    function automatic logic parity_bit(input logic [PARITY_MAX_WIDTH-1:0] data,
                                        input logic [1:0]                  ptype);
        logic bit_q;
        bit_q = 1'b0;
        case (ptype)
            PARITY_ODD:  bit_q = ~^data;
            PARITY_EVEN: bit_q = ^data;
            default:     bit_q = 1'b0;
        endcase
        return bit_q;
    endfunction

endpackage

// File: rtl/uart_rx_deframe_rx_sync_edge.sv
// Two-flop synchronizer for the serial line plus falling-edge detect.
module rx_sync_edge (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_rx,
    output logic o_rx_sync,
    output logic o_rx_fall_c
);

    logic r_meta;
    logic r_sync;
    logic r_prev;

    // Flops reset high so an idle line is not seen as a start edge.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_meta <= 1'b1;
            r_sync <= 1'b1;
            r_prev <= 1'b1;
        end else begin
            r_meta <= i_rx;
            r_sync <= r_meta;
            r_prev <= r_sync;
        end
    end

    assign o_rx_sync   = r_sync;
    assign o_rx_fall_c = r_prev & ~r_sync;

endmodule

// File: rtl/uart_rx_deframe.sv
// UART receive deframer: start/data/parity/stop sampling at mid-bit from a
// 16x oversampling enable, with parity and framing checks.
module uart_rx_deframe
    import uart_rx_deframe_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned OVERSAMPLE = 16
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_baud_tick,
    input  logic                  i_rx_in,
    input  logic [1:0]            i_parity_type,
    input  logic                  i_stop_bits,
    output logic [DATA_WIDTH-1:0] o_data_out,
    output logic                  o_done,
    output logic                  o_parity_error,
    output logic                  o_stop_error,
    output logic                  o_active
);

    localparam int unsigned TICK_W = $clog2(OVERSAMPLE);
    localparam int unsigned BIT_W  = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [TICK_W-1:0] MID_TICK  = TICK_W'(OVERSAMPLE / 2 - 1);
    localparam logic [TICK_W-1:0] LAST_TICK = TICK_W'(OVERSAMPLE - 1);
    localparam logic [BIT_W-1:0]  LAST_BIT  = BIT_W'(DATA_WIDTH - 1);

    rx_state_e             r_state;
    logic [TICK_W-1:0]     r_tick;
    logic [BIT_W-1:0]      r_bit;
    logic [DATA_WIDTH-1:0] r_shift;
    logic [1:0]            r_ptype;
    logic                  r_two_stop;
    logic                  r_stop_cnt;
    logic                  r_par_err;
    logic                  r_stop_err;

    logic w_rx_sync;
    logic w_rx_fall_c;
    logic w_bit_end;
    logic w_parity_exp;
    logic w_stop_err_final;

    rx_sync_edge u_sync (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_rx        (i_rx_in),
        .o_rx_sync   (w_rx_sync),
        .o_rx_fall_c (w_rx_fall_c)
    );

    // After the start mid-sample the counter is cleared, so every later
    // sample lands on the last tick of a full bit period.
    assign w_bit_end        = i_baud_tick && (r_tick == LAST_TICK);
    assign w_parity_exp     = parity_bit(PARITY_MAX_WIDTH'(r_shift), r_ptype);
    assign w_stop_err_final = r_stop_err | ~w_rx_sync;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state        <= ST_IDLE;
            r_tick         <= '0;
            r_bit          <= '0;
            r_shift        <= '0;
            r_ptype        <= PARITY_NONE;
            r_two_stop     <= 1'b0;
            r_stop_cnt     <= 1'b0;
            r_par_err      <= 1'b0;
            r_stop_err     <= 1'b0;
            o_data_out     <= '0;
            o_done         <= 1'b0;
            o_parity_error <= 1'b0;
            o_stop_error   <= 1'b0;
            o_active       <= 1'b0;
        end else begin
            o_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    o_active <= w_rx_fall_c;
                    if (w_rx_fall_c) begin
                        r_tick  <= '0;
                        r_state <= ST_START;
                    end
                end
                ST_START: begin
                    if (i_baud_tick) begin
                        if (r_tick == MID_TICK) begin
                            r_tick <= '0;
                            if (!w_rx_sync) begin
                                r_ptype    <= i_parity_type;
                                r_two_stop <= i_stop_bits;
                                r_bit      <= '0;
                                r_stop_cnt <= 1'b0;
                                r_par_err  <= 1'b0;
                                r_stop_err <= 1'b0;
                                r_state    <= ST_DATA;
                            end else begin
                                r_state <= ST_IDLE;
                            end
                        end else begin
                            r_tick <= r_tick + TICK_W'(1);
                        end
                    end
                end
                ST_DATA: begin
                    if (w_bit_end) begin
                        r_tick  <= '0;
                        r_shift <= {w_rx_sync, r_shift[DATA_WIDTH-1:1]};
                        if (r_bit == LAST_BIT) begin
                            r_state <= (r_ptype == PARITY_ODD || r_ptype == PARITY_EVEN)
                                       ? ST_PARITY : ST_STOP;
                        end else begin
                            r_bit <= r_bit + BIT_W'(1);
                        end
                    end else if (i_baud_tick) begin
                        r_tick <= r_tick + TICK_W'(1);
                    end
                end
                ST_PARITY: begin
                    if (w_bit_end) begin
                        r_tick    <= '0;
                        r_par_err <= (w_rx_sync != w_parity_exp);
                        r_state   <= ST_STOP;
                    end else if (i_baud_tick) begin
                        r_tick <= r_tick + TICK_W'(1);
                    end
                end
                ST_STOP: begin
                    if (w_bit_end) begin
                        r_tick <= '0;
                        if (r_two_stop && !r_stop_cnt) begin
                            r_stop_cnt <= 1'b1;
                            r_stop_err <= w_stop_err_final;
                        end else begin
                            o_data_out     <= r_shift;
                            o_parity_error <= r_par_err;
                            o_stop_error   <= w_stop_err_final;
                            o_done         <= 1'b1;
                            r_state        <= w_stop_err_final ? ST_BREAK : ST_IDLE;
                        end
                    end else if (i_baud_tick) begin
                        r_tick <= r_tick + TICK_W'(1);
                    end
                end
                ST_BREAK: begin
                    // A held-low line must return high before a new start is accepted.
                    o_active <= 1'b0;
                    if (i_baud_tick && w_rx_sync) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
